// File: rtl/if_fetch_stage.sv
// MIPS32 instruction fetch: owns the PC and presents IR/NPC to IF/ID. Optional IF_HALT_EN stops fetch on the HLT opcode.
// Latency: imem ack cycle -> valid_o on the next cycle; 1 instr/cycle with zero-wait memory.
// Backpressure: stall_i holds the output register and withdraws imem_req_o; redirect_i flushes it.
module if_fetch_stage #(
  parameter logic [31:0] RESET_PC    = 32'h0000_0000,
  parameter logic [5:0]  HALT_OPCODE = 6'b111111
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        stall_i,
  input  logic        redirect_i,
  input  logic [31:0] redirect_pc_i,
  output logic        imem_req_o,
  output logic [31:0] imem_addr_o,
  input  logic        imem_ack_i,
  input  logic [31:0] imem_rdata_i,
  output logic [31:0] npc_o,
  output logic [31:0] ir_o,
  output logic        valid_o,
  output logic        halted_o
);

`ifdef IF_HALT_EN
  typedef enum logic [1:0] {IDLE, RUN, HALTED} state_t;
`else
  typedef enum logic [1:0] {IDLE, RUN} state_t;
`endif

  state_t      state;
  logic [31:0] pc;
  logic [31:0] redirect_pc;
  logic        accept;
  logic        consume;
  logic        unused_ok;

  assign redirect_pc = {redirect_pc_i[31:2], 2'b00};
  assign imem_addr_o = pc;
  assign imem_req_o  = (state == RUN) && !(valid_o && stall_i) && !redirect_i;
  // req already excludes redirect, so an ack during redirect is never accepted
  assign accept      = imem_req_o && imem_ack_i;
  assign consume     = valid_o && !stall_i;

`ifdef IF_HALT_EN
  logic is_hlt;
  assign is_hlt    = (imem_rdata_i[31:26] == HALT_OPCODE);
  assign halted_o  = (state == HALTED);
  assign unused_ok = ^redirect_pc_i[1:0];
`else
  assign halted_o  = 1'b0;
  assign unused_ok = ^{redirect_pc_i[1:0], HALT_OPCODE};
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      pc      <= RESET_PC;
      npc_o   <= 32'h0;
      ir_o    <= 32'h0;
      valid_o <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          state <= RUN;
          if (redirect_i) pc <= redirect_pc;
        end
        RUN: begin
          if (redirect_i) begin
            pc      <= redirect_pc;
            valid_o <= 1'b0;
          end else if (accept) begin
            ir_o    <= imem_rdata_i;
            npc_o   <= pc + 32'd4;
            valid_o <= 1'b1;
            pc      <= pc + 32'd4;
`ifdef IF_HALT_EN
            if (is_hlt) state <= HALTED;
`endif
          end else if (consume) begin
            valid_o <= 1'b0;
          end
        end
`ifdef IF_HALT_EN
        // Redirects are ignored here; only reset leaves HALTED
        HALTED: begin
          if (consume) valid_o <= 1'b0;
        end
`endif
        default: state <= IDLE;
      endcase
    end
  end

endmodule
